// File: rtl/chorus_pkg.sv
// Shared types, gain constants and the stage-2 rounding arithmetic for the chorus wet/dry mixer.
package chorus_pkg;

   localparam int WIDTH      = 16;
   localparam int GAIN_W     = 8;
   localparam int GAIN_ONE   = 2**GAIN_W;
   localparam int ROUND_HALF = 2**(GAIN_W-1);
   localparam int PROD_W     = WIDTH + GAIN_W + 1;

   typedef logic signed [WIDTH-1:0]  sample_t;
   typedef logic signed [PROD_W-1:0] prod_t;

   // Convex weights keep the shifted sum inside sample range, so the narrowing cast never clips.
   function automatic sample_t mix_round(input prod_t pd, input prod_t pw);
      logic signed [PROD_W:0] sum;
      sum = {pd[PROD_W-1], pd} + {pw[PROD_W-1], pw} + (PROD_W+1)'(ROUND_HALF);
      return sample_t'(sum >>> GAIN_W);
   endfunction

endpackage

// File: rtl/chorus_pipe_reg.sv
// One elastic valid/ready register stage; ready looks through to the downstream ready.
module chorus_pipe_reg
   import chorus_pkg::*;
#(
   parameter int width_p = 1
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [width_p-1:0] data_o
);

   logic               r_valid;
   logic [width_p-1:0] r_data;

   assign ready_o = ~r_valid | ready_i;
   assign valid_o = r_valid;
   assign data_o  = r_data;

   // Load when there is room; otherwise drain on a downstream pop, holding data while stalled.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (valid_i && ready_o) begin
         r_valid <= 1'b1;
         r_data  <= data_i;
      end else if (ready_i) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/chorus_mix.sv
// Chorus wet/dry mixer: joins dry and wet streams, weights them by mix_i and rounds, two elastic stages.
// Optional CHORUS_MIX_BYPASS_EN adds bypass_i, which passes the dry sample through unchanged.
module chorus_mix
   import chorus_pkg::*;
#(
   parameter int width_p      = WIDTH,
   parameter int gain_width_p = GAIN_W
) (
   input  logic                    clk_i,
   input  logic                    reset_ni,
   input  logic [width_p-1:0]      dry_data_i,
   input  logic                    dry_valid_i,
   output logic                    dry_ready_o,
   input  logic [width_p-1:0]      wet_data_i,
   input  logic                    wet_valid_i,
   output logic                    wet_ready_o,
   input  logic [gain_width_p-1:0] mix_i,
`ifdef CHORUS_MIX_BYPASS_EN
   input  logic                    bypass_i,
`endif
   output logic                    valid_o,
   output logic [width_p-1:0]      data_o,
   input  logic                    ready_i
);

   localparam int P = width_p + gain_width_p + 1;

   logic                    w_s1_ready;
   logic                    w_s1_valid;
   logic                    w_s2_ready;
   logic [2*P-1:0]          w_s1_data;
   logic [gain_width_p:0]   w_dry_wt;
   logic [gain_width_p:0]   w_wet_wt;
   logic signed [P-1:0]     w_dry_ext;
   logic signed [P-1:0]     w_wet_ext;
   logic signed [P-1:0]     w_pd;
   logic signed [P-1:0]     w_pw;
   logic [width_p-1:0]      w_mixed;

   // A lone valid is never consumed: each side's ready waits on the other side's valid.
   assign dry_ready_o = wet_valid_i & w_s1_ready;
   assign wet_ready_o = dry_valid_i & w_s1_ready;

   // Weighted products; bypass scales dry by 2^G so the shared rounding returns it bit-exact.
   always_comb begin
      w_dry_wt  = (gain_width_p+1)'(GAIN_ONE) - {1'b0, mix_i};
      w_wet_wt  = {1'b0, mix_i};
      w_dry_ext = {{(gain_width_p+1){dry_data_i[width_p-1]}}, dry_data_i};
      w_wet_ext = {{(gain_width_p+1){wet_data_i[width_p-1]}}, wet_data_i};
`ifdef CHORUS_MIX_BYPASS_EN
      if (bypass_i) begin
         w_pd = w_dry_ext <<< gain_width_p;
         w_pw = '0;
      end else begin
         w_pd = w_dry_ext * $signed({{width_p{1'b0}}, w_dry_wt});
         w_pw = w_wet_ext * $signed({{width_p{1'b0}}, w_wet_wt});
      end
`else
      w_pd = w_dry_ext * $signed({{width_p{1'b0}}, w_dry_wt});
      w_pw = w_wet_ext * $signed({{width_p{1'b0}}, w_wet_wt});
`endif
   end

   chorus_pipe_reg #(.width_p(2*P)) u_stage1 (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .valid_i  (dry_valid_i & wet_valid_i),
      .ready_o  (w_s1_ready),
      .data_i   ({w_pd, w_pw}),
      .valid_o  (w_s1_valid),
      .ready_i  (w_s2_ready),
      .data_o   (w_s1_data)
   );

   assign w_mixed = mix_round(w_s1_data[2*P-1:P], w_s1_data[P-1:0]);

   chorus_pipe_reg #(.width_p(width_p)) u_stage2 (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .valid_i  (w_s1_valid),
      .ready_o  (w_s2_ready),
      .data_i   (w_mixed),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .data_o   (data_o)
   );

endmodule

// File: tb/tb_chorus_mix.sv
// Scoreboard bench for chorus_mix: expected mixes are queued at each input transfer and checked at each output pop.
module tb_chorus_mix;

   logic               clk = 1'b0;
   logic               reset_ni = 1'b0;
   logic signed [15:0] dry_data = '0;
   logic signed [15:0] wet_data = '0;
   logic               dry_valid = 1'b0;
   logic               wet_valid = 1'b0;
   logic               dry_ready_o;
   logic               wet_ready_o;
   logic [7:0]         mix = '0;
   logic               bypass = 1'b0;
   logic               valid_o;
   logic [15:0]        data_o;
   logic               ready_i = 1'b1;

   int q[$];
   int n_tests = 0;
   int n_fail  = 0;
   int n_xfer  = 0;
   int held;
   int x0;
   bit stall_done;

   chorus_mix #(.width_p(16), .gain_width_p(8)) dut (
      .clk_i       (clk),
      .reset_ni    (reset_ni),
      .dry_data_i  (dry_data),
      .dry_valid_i (dry_valid),
      .dry_ready_o (dry_ready_o),
      .wet_data_i  (wet_data),
      .wet_valid_i (wet_valid),
      .wet_ready_o (wet_ready_o),
      .mix_i       (mix),
`ifdef CHORUS_MIX_BYPASS_EN
      .bypass_i    (bypass),
`endif
      .valid_o     (valid_o),
      .data_o      (data_o),
      .ready_i     (ready_i)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model(input int d, input int w, input int m, input bit b);
      if (b) return d;
      return (d * (256 - m) + w * m + 128) >>> 8;
   endfunction

   // Scoreboard: pop/compare on output handshakes, push on input transfers.
   always @(negedge clk) begin
      if (reset_ni) begin
         if (valid_o && ready_i) begin
            check_eq("queue_nonempty", int'(q.size() > 0), 1);
            if (q.size() > 0) check_eq("data", int'($signed(data_o)), q.pop_front());
         end
         if (dry_valid && wet_valid && dry_ready_o && wet_ready_o) begin
            n_xfer++;
            q.push_back(model(int'(dry_data), int'(wet_data), int'(mix), bypass));
         end
      end
   end

   task automatic send_pair(input int d, input int w, input int m, input bit b);
      int n = 0;
      dry_data  = 16'(d);
      wet_data  = 16'(w);
      mix       = 8'(m);
      bypass    = b;
      dry_valid = 1'b1;
      wet_valid = 1'b1;
      @(negedge clk);
      while (!(dry_ready_o && wet_ready_o) && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) check_eq("send_timeout", n, 0);
      @(posedge clk);
      #1;
      dry_valid = 1'b0;
      wet_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || valid_o) && n < 100) begin
         n++;
         @(posedge clk);
         #1;
      end
      check_eq("drain_queue", q.size(), 0);
   endtask

   initial begin
      #12;
      check_eq("rst_valid", int'(valid_o), 0);
      check_eq("rst_data", int'(data_o), 0);
      check_eq("rst_dry_ready", int'(dry_ready_o), 0);
      @(negedge clk);
      reset_ni = 1'b1;
      @(posedge clk);
      #1;

      // Latency: valid_o must rise exactly two cycles after the pair is presented.
      dry_data = 16'sd1000; wet_data = -16'sd500; mix = 8'd0;
      dry_valid = 1'b1; wet_valid = 1'b1;
      @(posedge clk);
      #1;
      check_eq("lat_cyc1_valid", int'(valid_o), 0);
      dry_valid = 1'b0; wet_valid = 1'b0;
      @(posedge clk);
      #1;
      check_eq("lat_cyc2_valid", int'(valid_o), 1);
      check_eq("lat_data", int'($signed(data_o)), 1000);
      drain();

      send_pair(1000, -500, 128, 1'b0);
      send_pair(-32768, -32768, 255, 1'b0);
      send_pair(32767, 32767, 255, 1'b0);
      send_pair(1, 0, 128, 1'b0);
      send_pair(-1, 0, 128, 1'b0);
      send_pair(-32768, 32767, 0, 1'b0);
      drain();

      // Skew: dry alone for three cycles must not transfer.
      x0 = n_xfer;
      dry_data = 16'sd77; wet_data = 16'sd0; mix = 8'd10; bypass = 1'b0;
      dry_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("skew_dry_ready", int'(dry_ready_o), 0);
      end
      check_eq("skew_no_xfer", n_xfer - x0, 0);
      @(posedge clk);
      #1;
      send_pair(77, -300, 10, 1'b0);
      check_eq("skew_one_xfer", n_xfer - x0, 1);
      drain();

      // Stall: four pairs offered against a blocked output, two fit.
      ready_i = 1'b0;
      x0 = n_xfer;
      stall_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) send_pair(100 * i + 7, -50 * i - 3, 60 * i + 5, 1'b0);
            stall_done = 1'b1;
         end
      join_none
      repeat (3) @(posedge clk);
      #1;
      held = int'(data_o);
      check_eq("stall_valid", int'(valid_o), 1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_eq("stall_data_hold", int'(data_o), held);
         check_eq("stall_dry_ready", int'(dry_ready_o), 0);
         check_eq("stall_wet_ready", int'(wet_ready_o), 0);
      end
      check_eq("stall_accepted", n_xfer - x0, 2);
      ready_i = 1'b1;
      for (int n = 0; n < 100 && !stall_done; n++) @(posedge clk);
      check_eq("stall_sender_done", int'(stall_done), 1);
      drain();

      // Asynchronous reset mid-stream clears the outputs without a clock edge.
      ready_i = 1'b0;
      send_pair(1234, 567, 99, 1'b0);
      send_pair(-2222, 333, 17, 1'b0);
      @(posedge clk);
      #2;
      reset_ni = 1'b0;
      #1;
      check_eq("arst_valid", int'(valid_o), 0);
      check_eq("arst_data", int'(data_o), 0);
      q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_ni = 1'b1;
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      send_pair(4000, -4000, 64, 1'b0);
      drain();

`ifdef CHORUS_MIX_BYPASS_EN
      x0 = n_xfer;
      send_pair(-7, 300, 200, 1'b1);
      check_eq("bypass_wet_consumed", n_xfer - x0, 1);
      drain();
`endif

      // Random traffic with a toggling downstream ready.
      fork
         begin
            for (int i = 0; i < 16; i++)
               send_pair(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                         int'($urandom_range(0, 255)), 1'b0);
         end
         begin
            repeat (60) begin
               @(posedge clk);
               #1;
               ready_i = 1'($urandom_range(0, 1));
            end
            ready_i = 1'b1;
         end
      join
      ready_i = 1'b1;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
